uart_mem_loader: RTL

Serial boot loader for the single-cycle RV32I core on the DE10-Lite. It receives a framed program image over the board UART (`ser_rx`, 8N1) and assembles little-endian 32-bit words. It writes them sequentially into the core's word-addressed instruction/data memory, replacing the fixed hex-file preload with run-time loading. It holds the CPU in reset while a transfer is active and reports completion or error.

---
 rtl/uart_mem_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART (8N1) boot loader. It receives a framed image, packs
// the payload bytes into little-endian 32-bit words and writes them to
// word-addressed memory. The CPU is held in reset while a frame is in flight.
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12,
  parameter int MEM_WORDS    = 2056
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_CNT_LO, L_CNT_HI, L_DATA, L_SUM, L_DONE, L_ERR} ld_state_t;

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2;
  rx_state_t     r_state, r_next;
  logic [CW-1:0] tcnt, tcnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    rx_byte, rx_byte_n;
  logic          rx_valid, rx_valid_n, rx_ferr, rx_ferr_n;

  // two-flop synchronizer, idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
    end
  end

  // receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= R_IDLE;
      tcnt     <= '0;
      bitn     <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      r_state  <= r_next;
      tcnt     <= tcnt_n;
      bitn     <= bitn_n;
      rx_byte  <= rx_byte_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  // bit timing: tcnt counts cycles since the last reference point
  always_comb begin
    r_next     = r_state;
    tcnt_n     = tcnt + CW'(1);
    bitn_n     = bitn;
    rx_byte_n  = rx_byte;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (r_state)
      R_IDLE: begin
        tcnt_n = CW'(1);
        if (!rx_s2) r_next = R_START;
      end
      R_START: if (tcnt == HALF) begin
        // still low at mid start bit: real start; otherwise a glitch
        if (rx_s2) r_next = R_IDLE;
        else begin
          r_next = R_DATA;
          tcnt_n = CW'(1);
          bitn_n = '0;
        end
      end
      R_DATA: if (tcnt == FULL) begin
        tcnt_n    = CW'(1);
        rx_byte_n = {rx_s2, rx_byte[7:1]};
        bitn_n    = bitn + 3'd1;
        if (bitn == 3'd7) r_next = R_STOP;
      end
      R_STOP: if (tcnt == FULL) begin
        r_next = R_IDLE;
        if (rx_s2) rx_valid_n = 1'b1;
        else       rx_ferr_n  = 1'b1;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_t        l_state, l_next;
  logic [7:0]       cnt_lo, cnt_lo_n, sum, sum_n;
  logic [23:0]      shift, shift_n;
  logic [1:0]       bidx, bidx_n;
  logic [15:0]      wcnt, wcnt_n;
  logic [15:0]      n_words;
  logic             we_n, hold_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]      wdata_n;

  assign n_words = {rx_byte, cnt_lo};

  // loader state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      l_state   <= L_IDLE;
      cnt_lo    <= '0;
      sum       <= '0;
      shift     <= '0;
      bidx      <= '0;
      wcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      l_state   <= l_next;
      cnt_lo    <= cnt_lo_n;
      sum       <= sum_n;
      shift     <= shift_n;
      bidx      <= bidx_n;
      wcnt      <= wcnt_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      cpu_hold  <= hold_n;
      load_done <= done_n;
      load_err  <= err_n;
    end
  end

  // frame parsing; address advances the cycle after the write strobe
  always_comb begin
    l_next   = l_state;
    cnt_lo_n = cnt_lo;
    sum_n    = sum;
    shift_n  = shift;
    bidx_n   = bidx;
    wcnt_n   = wcnt;
    we_n     = 1'b0;
    addr_n   = mem_we ? mem_addr + ADDR_W'(1) : mem_addr;
    wdata_n  = mem_wdata;
    hold_n   = cpu_hold;
    done_n   = load_done;
    err_n    = load_err;
    case (l_state)
      L_IDLE, L_DONE, L_ERR: if (rx_valid && rx_byte == 8'hA5) begin
        l_next = L_CNT_LO;
        done_n = 1'b0;
        err_n  = 1'b0;
        hold_n = 1'b1;
        addr_n = '0;
        sum_n  = '0;
        bidx_n = '0;
      end
      L_CNT_LO: if (rx_valid) begin
        cnt_lo_n = rx_byte;
        l_next   = L_CNT_HI;
      end
      L_CNT_HI: if (rx_valid) begin
        if (n_words > 16'(MEM_WORDS)) begin
          l_next = L_ERR;
          err_n  = 1'b1;
          hold_n = 1'b0;
        end else if (n_words == 16'd0) begin
          l_next = L_SUM;
        end else begin
          l_next = L_DATA;
          wcnt_n = n_words;
        end
      end
      L_DATA: if (rx_valid) begin
        sum_n   = sum ^ rx_byte;
        bidx_n  = bidx + 2'd1;
        shift_n = {rx_byte, shift[23:8]};
        if (bidx == 2'd3) begin
          we_n    = 1'b1;
          wdata_n = {rx_byte, shift};
          wcnt_n  = wcnt - 16'd1;
          if (wcnt == 16'd1) l_next = L_SUM;
        end
      end
      L_SUM: if (rx_valid) begin
        hold_n = 1'b0;
        if (rx_byte == sum) begin
          l_next = L_DONE;
          done_n = 1'b1;
        end else begin
          l_next = L_ERR;
          err_n  = 1'b1;
        end
      end
      default: l_next = L_IDLE;
    endcase
    // a bad stop bit aborts an in-progress frame only
    if (rx_ferr && (l_state inside {L_CNT_LO, L_CNT_HI, L_DATA, L_SUM})) begin
      l_next = L_ERR;
      err_n  = 1'b1;
      hold_n = 1'b0;
    end
  end

endmodule
